serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Sequencer and bit-serial adder core for the serial adder. On a start handshake it pulses `load_o` into the parallel-to-serial operand shift register, then drives `enable_o` for WIDTH cycles. It adds the returned LSB-first operand bits with a registered carry, assembles the WIDTH-bit sum and carry-out, and signals completion with a one-cycle `done_o`. It sits between the top-level request interface and the operand shift register.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 2–64.
- `clk_i`  input  1  clock; all logic on the rising edge.
- `reset_n_i`  input  1  asynchronous active-low reset.
- `start_i`  input  1  request a new addition; accepted only when `ready_o`=1.
- `cin_i`  input  1  carry-in, captured on an accepted start.
- `a_bit_i`  input  1  serial operand A bit from the shift register.
- `b_bit_i`  input  1  serial operand B bit from the shift register.
- `ready_o`  output  1  controller can accept `start_i` (states IDLE, DONE).
- `load_o`  output  1  shift-register parallel load strobe.
- `enable_o`  output  1  shift-register shift enable.
- `busy_o`  output  1  operation in progress (states LOAD, RUN).
- `done_o`  output  1  one-cycle completion pulse.
- `sum_o`  output  WIDTH  result, held stable until the next accepted start.
- `cout_o`  output  1  final carry-out, held with `sum_o`.
- `ovf_o`  output  1  signed overflow (see Configuration).

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Encoding is free.
- IDLE: `ready_o`=1. If `start_i`=1 → LOAD and capture `cin_i` into the carry register.
- LOAD: `load_o`=1 for exactly one cycle. Clear the bit counter, issue counter and sum register. → RUN.
- RUN, bit issue: `enable_o`=1 while issue count < WIDTH, i.e. exactly WIDTH consecutive cycles starting with the first RUN cycle.
- RUN, sampling: the shift register presents bit k one cycle after its k-th enable. `sample_q` is `enable_o` delayed by one flop.
- RUN, per sampled cycle:
  - s = a^b^c; c ← maj(a,b,c).
  - sum register shifts right with s inserted at the MSB.
  - Bit counter increments.
- RUN exit: when the counter reaches WIDTH on a sample → DONE. RUN therefore lasts WIDTH+1 cycles.
- DONE:
  - `done_o`=1; `sum_o`, `cout_o`, `ovf_o` valid.
  - `ready_o`=1. `start_i`=1 → LOAD (back-to-back operation); otherwise → IDLE.
- `load_o` and `enable_o` are never high in the same cycle.
- `start_i` in LOAD or RUN is ignored and not queued.
- `sum_o`/`cout_o` keep the last result through IDLE. They are overwritten progressively during RUN. Only values sampled with `done_o`=1 are valid.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `load_o`=0, `enable_o`=0, `busy_o`=0, `done_o`=0, `sum_o`=0, `cout_o`=0, `ovf_o`=0; counters and carry = 0.
- Start accepted at edge T:
  - LOAD in cycle T+1.
  - `enable_o` high in cycles T+2 … T+WIDTH+1.
  - Samples in cycles T+3 … T+WIDTH+2.
  - `done_o` in cycle T+WIDTH+3.
- Latency from start edge to `done_o` = WIDTH+3 cycles; 11 for WIDTH=8.
- Throughput with back-to-back starts: one result per WIDTH+3 cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously), with no `done_o`. The next start after release behaves as a fresh operation.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- Defined:
  - An extra flop captures the carry into the MSB, taken on the WIDTH-th sample.
  - `ovf_o` = carry_into_MSB ^ `cout_o`, registered and valid with `done_o`.
- Undefined:
  - `ovf_o` is tied to 0 and no extra flop exists.
  - All other behaviour and timing are identical.

## Test plan
- 8'h0F + 8'h01, cin=0 → `done_o` exactly 11 cycles after the start edge; `sum_o`=8'h10, `cout_o`=0; `enable_o` high exactly 8 cycles; `load_o` high exactly 1 cycle.
- 8'hFF + 8'h01, cin=0 → `sum_o`=8'h00, `cout_o`=1, `ovf_o`=0. Also 8'hFF + 8'h00, cin=1 → `sum_o`=8'h00, `cout_o`=1.
- 8'h7F + 8'h01 → `sum_o`=8'h80, `cout_o`=0. `ovf_o`=1 with `SERIAL_ADDER_OVF_EN`, 0 without.
- `start_i` pulsed in RUN (cycle T+5) → ignored: single `done_o`, result unchanged, no extra `load_o`.
- `start_i` held high in DONE with new operands 8'h03 + 8'h04 → LOAD next cycle; second `done_o` 11 cycles after the first; `sum_o`=8'h07.
- `reset_n_i` low during cycle T+6 of an 8'hAA + 8'h55 add → all outputs reset immediately, no `done_o`. A subsequent 8'h01 + 8'h01 gives `sum_o`=8'h02.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Sequencer and bit-serial adder core: loads the operand shift register, issues
// WIDTH shift enables, accumulates LSB-first sum bits. Optional SERIAL_ADDER_OVF_EN adds signed overflow.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             cin_i,
    input  logic             a_bit_i,
    input  logic             b_bit_i,
    output logic             ready_o,
    output logic             load_o,
    output logic             enable_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    issue_cnt_r;
    logic [CW-1:0]    bit_cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             sample_r;
    logic             enable_r;
    logic             load_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             enable_s;
    logic             accept_s;
    logic             last_sample_s;
    logic             sum_bit_s;
    logic             carry_s;

    // Next-state, next shift enable and full-adder terms.
    always_comb begin
        state_s       = state_r;
        enable_s      = 1'b0;
        accept_s      = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_sample_s = (state_r == ST_RUN) && sample_r && (bit_cnt_r == LAST_IDX);
        sum_bit_s     = a_bit_i ^ b_bit_i ^ carry_r;
        carry_s       = maj3(a_bit_i, b_bit_i, carry_r);
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s  = ST_RUN;
                enable_s = 1'b1;
            end
            ST_RUN: begin
                if (last_sample_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
                // issue_cnt_r holds the number of enables already issued before this one
                if (enable_r && (issue_cnt_r != LAST_IDX)) begin
                    enable_s = 1'b1;
                end else begin
                    enable_s = 1'b0;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b1;
            load_r   <= 1'b0;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sample_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            ready_r  <= (state_s == ST_IDLE) || (state_s == ST_DONE);
            load_r   <= (state_s == ST_LOAD);
            enable_r <= enable_s;
            busy_r   <= (state_s == ST_LOAD) || (state_s == ST_RUN);
            done_r   <= (state_s == ST_DONE);
            sample_r <= enable_r;
        end
    end

    // Counters, running carry and sum accumulator.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issue_cnt_r <= '0;
            bit_cnt_r   <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                carry_r <= cin_i;
            end else if ((state_r == ST_RUN) && sample_r) begin
                carry_r <= carry_s;
            end
            if (state_r == ST_LOAD) begin
                issue_cnt_r <= '0;
                bit_cnt_r   <= '0;
                sum_r       <= '0;
            end else if (state_r == ST_RUN) begin
                if (enable_r) begin
                    issue_cnt_r <= issue_cnt_r + CW'(1);
                end
                if (sample_r) begin
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                    sum_r     <= {sum_bit_s, sum_r[WIDTH-1:1]};
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // On the MSB sample carry_r is the carry into the MSB and carry_s the carry out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovf_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            ovf_r <= 1'b0;
        end else if (last_sample_s) begin
            ovf_r <= carry_r ^ carry_s;
        end
    end

    assign ovf_o = ovf_r;
`else
    assign ovf_o = 1'b0;
`endif

    assign ready_o  = ready_r;
    assign load_o   = load_r;
    assign enable_o = enable_r;
    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign sum_o    = sum_r;
    assign cout_o   = carry_r;

endmodule
